alu_share_arbiter: RTL and testbench

//   Shares one alu_module instance between NREQ requesters (e.g. execute stage,

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_module.sv | 44 ++++
 rtl/alu_share_arbiter_rr_arbiter.sv | 43 ++++
 rtl/alu_share_arbiter.sv | 92 +++++++++
 tb/tb_alu_share_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode constants and shared result type
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] ALU_ADD     = 4'd0;
  localparam logic [SEL_W-1:0] ALU_SUB     = 4'd1;
  localparam logic [SEL_W-1:0] ALU_LUI     = 4'd2;
  localparam logic [SEL_W-1:0] ALU_SLL     = 4'd3;
  localparam logic [SEL_W-1:0] ALU_SRL     = 4'd4;
  localparam logic [SEL_W-1:0] ALU_SRA     = 4'd5;
  localparam logic [SEL_W-1:0] ALU_XOR     = 4'd6;
  localparam logic [SEL_W-1:0] ALU_OR      = 4'd7;
  localparam logic [SEL_W-1:0] ALU_AND     = 4'd8;
  localparam logic [SEL_W-1:0] ALU_SLT     = 4'd9;
  localparam logic [SEL_W-1:0] ALU_SLTU    = 4'd10;
  localparam logic [SEL_W-1:0] ALU_SEL_MAX = 4'd10;

  // Everything the ALU produces for one op, captured together in the response slot
  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              negative;
    logic              illegal;
  } alu_out_t;

endpackage

// File: rtl/alu_module.sv
// rtl/alu_module.sv - combinational 32-bit ALU with compare flags
module alu_module
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_negative,
  output logic              o_illegal
);

  logic [DATA_W-1:0] w_diff;
  logic [4:0]        w_shamt;

  assign w_diff  = i_op1 - i_op2;
  assign w_shamt = i_op2[4:0];

  // Flags always come from op1-op2 so branch compare can use them with any opcode
  assign o_zero     = (w_diff == '0);
  assign o_negative = w_diff[DATA_W-1];
  assign o_illegal  = (i_sel > ALU_SEL_MAX);

  // Opcode decode; undefined opcodes yield zero
  always_comb begin
    o_result = '0;
    case (i_sel)
      ALU_ADD:  o_result = i_op1 + i_op2;
      ALU_SUB:  o_result = w_diff;
      ALU_LUI:  o_result = i_op2;
      ALU_SLL:  o_result = i_op1 << w_shamt;
      ALU_SRL:  o_result = i_op1 >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_op1) >>> w_shamt);
      ALU_XOR:  o_result = i_op1 ^ i_op2;
      ALU_OR:   o_result = i_op1 | i_op2;
      ALU_AND:  o_result = i_op1 & i_op2;
      ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, (i_op1 < i_op2)};
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rtl/alu_share_arbiter_rr_arbiter.sv - round-robin one-hot grant with owned pointer
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_enable,
  output logic [NREQ-1:0] o_grant
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_pos;
  logic [PTR_W-1:0] w_win;
  logic             w_found;

  // Scan upward from the pointer with wrap; the first requester found wins
  always_comb begin
    o_grant = '0;
    w_win   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = PTR_W'((int'(r_ptr) + k) % NREQ);
      if (!w_found && i_enable && i_req[w_pos]) begin
        w_found        = 1'b1;
        w_win          = w_pos;
        o_grant[w_pos] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_win == PTR_W'(NREQ-1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - one ALU shared by NREQ requesters with a registered response slot
module alu_share_arbiter #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_op1,
  input  logic [NREQ*DATA_W-1:0] req_op2,
  input  logic [NREQ*SEL_W-1:0]  req_sel,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_res,
  output logic                   rsp_zero,
  output logic                   rsp_negative,
  output logic                   rsp_illegal
);

  import alu_pkg::*;

  logic [NREQ-1:0]   r_rsp_valid;
  alu_out_t          r_rsp;
  alu_out_t          w_alu;
  logic [NREQ-1:0]   w_grant;
  logic              w_slot_free;
  logic              w_accept;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic [SEL_W-1:0]  w_sel;

  // The slot can take a new op if empty or being drained this very cycle
  assign w_slot_free = !(|r_rsp_valid) || (|(r_rsp_valid & rsp_ready));
  assign w_accept    = |w_grant;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (req_valid),
    .i_enable (w_slot_free && rst_n),
    .o_grant  (w_grant)
  );

  // One-hot AND-OR mux of the granted requester's operands into the ALU
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_op1 = req_op1[i*DATA_W +: DATA_W];
        w_op2 = req_op2[i*DATA_W +: DATA_W];
        w_sel = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  alu_module u_alu (
    .i_op1      (w_op1),
    .i_op2      (w_op2),
    .i_sel      (w_sel),
    .o_result   (w_alu.res),
    .o_zero     (w_alu.zero),
    .o_negative (w_alu.negative),
    .o_illegal  (w_alu.illegal)
  );

  // Response slot: reload on accept, empty on drain, otherwise hold under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp       <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= w_grant;
      r_rsp       <= w_alu;
    end else if (w_slot_free) begin
      r_rsp_valid <= '0;
    end
  end

  assign req_ready    = w_grant;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_res      = r_rsp.res;
  assign rsp_zero     = r_rsp.zero;
  assign rsp_negative = r_rsp.negative;
  assign rsp_illegal  = r_rsp.illegal;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed and soak checks of the shared ALU arbiter
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int SW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_op1;
  logic [NREQ*DW-1:0] req_op2;
  logic [NREQ*SW-1:0] req_sel;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [DW-1:0]     rsp_res;
  logic              rsp_zero;
  logic              rsp_negative;
  logic              rsp_illegal;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_sel      (req_sel),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_res      (rsp_res),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative),
    .rsp_illegal  (rsp_illegal)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU written straight from the opcode table
  function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return b;
      4'd3:    return a << b[4:0];
      4'd4:    return a >> b[4:0];
      4'd5:    return $unsigned($signed(a) >>> b[4:0]);
      4'd6:    return a ^ b;
      4'd7:    return a | b;
      4'd8:    return a & b;
      4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10:   return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Model: which requester owns the held result (-1 none), its contents, and the rr pointer
  int          m_dst = -1;
  logic [31:0] m_res = '0;
  logic        m_zero = 1'b0;
  logic        m_neg = 1'b0;
  logic        m_ill = 1'b0;
  int          m_ptr = 0;
  int          acc_total = 0;
  int          dlv_total = 0;

  always @(negedge clk) begin : cmp
    logic [NREQ-1:0] exp_rv;
    logic [NREQ-1:0] exp_rdy;
    logic [31:0]     a, b, d;
    logic [3:0]      s;
    bit              free;
    int              g;
    exp_rv = '0;
    if (m_dst >= 0) exp_rv[m_dst] = 1'b1;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_res", rsp_res, m_res);
    chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
    chk("rsp_negative", 32'(rsp_negative), 32'(m_neg));
    chk("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
    free = (m_dst < 0) || (rsp_ready[m_dst] == 1'b1);
    if (rst_n && m_dst >= 0 && rsp_ready[m_dst]) dlv_total++;
    g = -1;
    if (rst_n && free) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (!rst_n) begin
      m_dst = -1; m_res = '0; m_zero = 1'b0; m_neg = 1'b0; m_ill = 1'b0; m_ptr = 0;
    end else if (g >= 0) begin
      a = req_op1[g*DW +: DW];
      b = req_op2[g*DW +: DW];
      s = req_sel[g*SW +: SW];
      d = a - b;
      m_res  = ref_alu(s, a, b);
      m_zero = (d == 32'd0);
      m_neg  = d[31];
      m_ill  = (s > 4'd10);
      m_dst  = g;
      m_ptr  = (g + 1) % NREQ;
      acc_total++;
    end else if (free) begin
      m_dst = -1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    req_sel[i*SW +: SW] = s;
    req_op1[i*DW +: DW] = a;
    req_op2[i*DW +: DW] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0] e;
  logic [NREQ-1:0] acc;
  int              cnt [NREQ];
  int              a0, d0;

  initial begin
    req_op1 = '0;
    req_op2 = '0;
    req_sel = '0;

    // Pin the reference ALU on a few hand-worked values
    chk("ref sra", ref_alu(ALU_SRA, 32'h8000_0000, 32'd4), 32'hF800_0000);
    chk("ref slt", ref_alu(ALU_SLT, 32'hFFFF_FFFF, 32'd1), 32'd1);
    chk("ref sltu", ref_alu(ALU_SLTU, 32'hFFFF_FFFF, 32'd1), 32'd0);
    chk("ref sll", ref_alu(ALU_SLL, 32'd1, 32'd33), 32'd2);

    do_reset();
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_res", rsp_res, 32'd0);

    // Single op
    set_req(0, ALU_ADD, 32'd6, 32'd5);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1 ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("t1 rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1 res", rsp_res, 32'd11);
    chk("t1 zero", 32'(rsp_zero), 32'd0);
    chk("t1 neg", 32'(rsp_negative), 32'd0);
    next_cycle();

    // Contention between req0 and req1
    do_reset();
    set_req(0, ALU_SUB, 32'd3, 32'd3);
    set_req(1, ALU_SLTU, 32'd2, 32'd7);
    req_valid = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t2 grant", 32'(req_ready), (c % 2 == 1) ? 32'h2 : 32'h1);
      if (c == 1) begin
        chk("t2 rsp0 valid", 32'(rsp_valid), 32'h1);
        chk("t2 rsp0 res", rsp_res, 32'd0);
        chk("t2 rsp0 zero", 32'(rsp_zero), 32'd1);
      end
      if (c == 2) begin
        chk("t2 rsp1 valid", 32'(rsp_valid), 32'h2);
        chk("t2 rsp1 res", rsp_res, 32'd1);
        chk("t2 rsp1 neg", 32'(rsp_negative), 32'd1);
      end
      next_cycle();
    end
    req_valid = '0;

    // Backpressure holds the slot and blocks grants
    do_reset();
    set_req(0, ALU_SRA, 32'h8000_0000, 32'd4);
    set_req(1, ALU_ADD, 32'd1, 32'd2);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t3 ready0", 32'(req_ready), 32'h1);
    next_cycle();
    rsp_ready = '0;
    req_valid = 4'b0010;
    repeat (3) begin
      @(negedge clk);
      chk("t3 hold res", rsp_res, 32'hF800_0000);
      chk("t3 hold valid", 32'(rsp_valid), 32'h1);
      chk("t3 no grant", 32'(req_ready), 32'h0);
      next_cycle();
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    chk("t3 regrant", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = '0;
    rsp_ready = '1;
    @(negedge clk);
    chk("t3 rsp1 res", rsp_res, 32'd3);
    chk("t3 rsp1 valid", 32'(rsp_valid), 32'h2);
    next_cycle();

    // Illegal opcode
    do_reset();
    set_req(1, 4'hF, 32'd5, 32'd9);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t4 ready", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("t4 rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t4 res", rsp_res, 32'd0);
    chk("t4 illegal", 32'(rsp_illegal), 32'd1);
    next_cycle();

    // Reset while a result is held
    do_reset();
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    req_valid = 4'b0001;
    rsp_ready = '0;
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("t5 held", 32'(rsp_valid), 32'h1);
    next_cycle();
    rst_n = 1'b0;
    set_req(1, ALU_OR, 32'd4, 32'd1);
    req_valid = 4'b0011;
    @(negedge clk);
    chk("t5 ready in reset", 32'(req_ready), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("t5 dropped", 32'(rsp_valid), 32'h0);
    chk("t5 res cleared", rsp_res, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    rsp_ready = '1;
    @(negedge clk);
    chk("t5 req0 first", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;

    // Fairness with all four requesting
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, ALU_ADD, 32'(i), 32'(10 * i));
      cnt[i] = 0;
    end
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      e = 4'b0001 << (c % 4);
      chk("t6 order", 32'(req_ready), 32'(e));
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
      next_cycle();
    end
    for (int i = 0; i < NREQ; i++) chk("t6 count", 32'(cnt[i]), 32'd4);
    req_valid = '0;
    repeat (2) next_cycle();

    // Random soak: requests held until accepted, random response backpressure
    a0 = acc_total;
    d0 = dlv_total;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      next_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    acc = req_valid & req_ready;
    next_cycle();
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) next_cycle();
    chk("soak no drop/dup", 32'(dlv_total - d0), 32'(acc_total - a0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
